mem_issue: RTL
==============

Name: mem_issue

Overview:
- Consumer of effective addresses produced by the address generator.
- Takes one load/store request at a time and runs it as one or two Wishbone-classic bus cycles.
- Returns load data, sign- or zero-extended, tagged with the issuing queue id, plus an exception code.
- Sits between the load/store queue and the data-cache/bus interface.

Parameters:
AMSB, 31, address MSB; address width AMSB+1
DBW, 64, data bus width in bits (8-bit lanes, DBW/8 select bits)
TAGW, 4, request tag width
TMO, 255, bus-cycle timeout in clocks (max 255)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  block accepts a request this cycle
req_id_i  in  TAGW  request tag
req_we_i  in  1  1=store, 0=load
req_sz_i  in  2  0=byte,1=wyde(2),2=tetra(4),3=octa(8)
req_sxt_i  in  1  sign-extend load result
req_adr_i  in  AMSB+1  effective address
req_dat_i  in  DBW  store data, right-justified
res_valid_o  out  1  one-cycle result pulse
res_id_o  out  TAGW  tag of completed request
res_dat_o  out  DBW  load data, extended; 0 for stores
res_exc_o  out  2  0=none,1=bus error,2=timeout,3=misaligned
cyc_o, stb_o, we_o  out  1 each  bus cycle controls
sel_o  out  DBW/8  byte lane selects
adr_o  out  AMSB+1  bus address, lane-aligned (low 3 bits 0)
dat_o  out  DBW  store data, lane-shifted
ack_i, err_i  in  1 each  bus acknowledge / error
dat_i  in  DBW  bus read data
idle_o  out  1  high in IDLE with no result pending

Behaviour:
- Reset: state IDLE; cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, res_* all 0; req_ready_o=1; idle_o=1.
- rst_i asserted mid-access: the bus cycle is abandoned next edge (cyc_o=0) and no result is emitted.
- Handshake: transfer occurs when req_valid_i && req_ready_o. req_ready_o=1 only in IDLE. All request fields are latched at transfer.
- Lane mask: m = (1<<bytes)-1, o = adr[2:0], full mask = m<<o (16 bits).
  - Low half drives sel in cycle 1.
  - High half drives sel in cycle 2 at adr+8.
- Split: a request needs two cycles when o+bytes>8.
- States:
  - IDLE: on accept go to ACC1; cyc_o=stb_o=1 on the following cycle.
  - ACC1: hold bus signals until ack_i, err_i, or timeout.
    - ack_i and no split: go to DONE.
    - ack_i and split: capture low data, drop stb_o for one cycle (cyc_o held), go to ACC2.
  - ACC2: second cycle; on ack_i go to DONE.
  - DONE: one cycle, res_valid_o=1; return to IDLE.
- Latency, unsplit access with 0-wait ack: request accepted cycle N, stb_o N+1, ack N+1, res_valid_o N+2.
- err_i in ACC1 or ACC2: end the cycle, go to DONE with exc=1, res_dat_o=0.
  - err_i and ack_i together: err_i wins.
- Timeout: an 8-bit counter clears on entry to ACC1/ACC2 and increments while waiting. When it reaches TMO: drop cyc_o, go to DONE with exc=2.
- Load data: the merged 16-byte read is shifted right by 8*o, truncated to bytes, then sign-extended if req_sxt_i, else zero-extended.
- Stores: dat_o = req_dat<<(8*o) for cycle 1, the upper part for cycle 2. res_dat_o=0.
- Octa loads use the full DBW; extension is a no-op.

Optional Feature:
MEMISSUE_SPLIT_EN
- Defined: misaligned accesses are split into two bus cycles as above.
- Undefined: a request with o+bytes>8 runs no bus cycle; DONE is reached 1 cycle after accept with exc=3. The ACC2 state and high-half logic are not built.

Decomposition:
- Shared package:
  - access-size enum (byte/wyde/tetra/octa)
  - exception-code enum
  - state enum
  - function sz_to_bytes
- Sub-module lane_align: combinational mask/shift/extend for both directions (sel generation, store shift, load merge and extension). Keeps the FSM file small and is reusable by the cache.

Test Plan:
- Load tetra at adr 0x104, sxt=1, 0-wait ack with dat_i=0x80000000_00000000: sel_o=0xF0; res_dat_o=0xFFFFFFFF_80000000 two clocks after accept; exc=0.
- Store wyde 0xBEEF at adr 0x202: sel_o=0x0C, dat_o=0x00000000_BEEF0000, we_o=1; res_valid_o with exc=0, res_dat_o=0.
- Split (MEMISSUE_SPLIT_EN): load octa at 0x106, no sxt.
  - Cycle 1: adr 0x100, sel 0xC0. Cycle 2: adr 0x108, sel 0x3F, with a one-clock stb_o gap.
  - Merged bytes returned correctly.
  - Without the macro: no cyc_o, exc=3.
- err_i and ack_i both asserted on the first cycle: exc=1, res_dat_o=0; req_ready_o high the cycle after DONE.
- Timeout: no ack for TMO=255 clocks: cyc_o drops, res_valid_o with exc=2, res_id_o equals the accepted tag.
- rst_i asserted while stb_o=1 in ACC2: next edge all bus outputs 0, idle_o=1, no res_valid_o pulse.

Source files
------------

// File: rtl/mem_issue_pkg.sv
// rtl/mem_issue_pkg.sv - shared types and helpers for the memory issue block
package mem_issue_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_WYDE  = 2'd1,
    SZ_TETRA = 2'd2,
    SZ_OCTA  = 2'd3
  } sz_e;

  typedef enum logic [1:0] {
    EXC_NONE  = 2'd0,
    EXC_BUS   = 2'd1,
    EXC_TMO   = 2'd2,
    EXC_ALIGN = 2'd3
  } exc_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC1 = 3'd1,
    ST_GAP  = 3'd2,
    ST_ACC2 = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Number of bytes moved by an access of the given size.
  function automatic logic [3:0] sz_to_bytes(input sz_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/mem_issue_lane_align.sv
// rtl/mem_issue_lane_align.sv - byte-lane select, store shift and load merge/extend
module lane_align
  import mem_issue_pkg::*;
#(
  parameter int DBW = 64
) (
  input  logic [1:0]               i_sz,
  input  logic [$clog2(DBW/8)-1:0] i_off,
  input  logic                     i_sxt,
  input  logic [DBW-1:0]           i_st_dat,
  input  logic [DBW-1:0]           i_rd_lo,
  input  logic [DBW-1:0]           i_rd_hi,
  output logic [DBW/8-1:0]         o_sel_lo,
  output logic [DBW/8-1:0]         o_sel_hi,
  output logic [DBW-1:0]           o_st_lo,
  output logic [DBW-1:0]           o_st_hi,
  output logic [DBW-1:0]           o_ld_dat
);
  localparam int NB = DBW / 8;
  localparam logic [2*NB-1:0] ONE = 1;

  logic [3:0]       w_bytes;
  logic [2*NB-1:0]  w_mask;
  logic [2*NB-1:0]  w_full;
  logic [DBW-1:0]   w_dmask;
  logic [2*DBW-1:0] w_st;
  logic [2*DBW-1:0] w_ld_sh;
  logic [DBW-1:0]   w_raw;
  logic             w_sign;

  // Lane mask spans two lane groups; data is shifted across the same double-width window.
  always_comb begin
    w_bytes  = sz_to_bytes(sz_e'(i_sz));
    w_mask   = (ONE << w_bytes) - ONE;
    w_full   = w_mask << i_off;
    o_sel_lo = w_full[NB-1:0];
    o_sel_hi = w_full[2*NB-1:NB];
    w_dmask  = ~({DBW{1'b1}} << {w_bytes, 3'b000});
    w_st     = {{DBW{1'b0}}, i_st_dat & w_dmask} << {i_off, 3'b000};
    o_st_lo  = w_st[DBW-1:0];
    o_st_hi  = w_st[2*DBW-1:DBW];
    w_ld_sh  = {i_rd_hi, i_rd_lo} >> {i_off, 3'b000};
    w_raw    = w_ld_sh[DBW-1:0] & w_dmask;
    w_sign   = 1'b0;
    case (sz_e'(i_sz))
      SZ_BYTE:  w_sign = w_raw[7];
      SZ_WYDE:  w_sign = w_raw[15];
      SZ_TETRA: w_sign = w_raw[31];
      default:  w_sign = w_raw[DBW-1];
    endcase
    o_ld_dat = (i_sxt && w_sign) ? (w_raw | ~w_dmask) : w_raw;
  end

endmodule

// File: rtl/mem_issue.sv
// rtl/mem_issue.sv - load/store bus issue FSM; MEMISSUE_SPLIT_EN enables two-cycle misaligned accesses
module mem_issue
  import mem_issue_pkg::*;
#(
  parameter int AMSB = 31,
  parameter int DBW  = 64,
  parameter int TAGW = 4,
  parameter int TMO  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [TAGW-1:0]   req_id_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_sz_i,
  input  logic              req_sxt_i,
  input  logic [AMSB:0]     req_adr_i,
  input  logic [DBW-1:0]    req_dat_i,
  output logic              res_valid_o,
  output logic [TAGW-1:0]   res_id_o,
  output logic [DBW-1:0]    res_dat_o,
  output logic [1:0]        res_exc_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [DBW/8-1:0]  sel_o,
  output logic [AMSB:0]     adr_o,
  output logic [DBW-1:0]    dat_o,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic [DBW-1:0]    dat_i,
  output logic              idle_o
);
  localparam int NB = DBW / 8;
  localparam int OW = $clog2(NB);

  state_e          r_state, w_nxt;
  exc_e            r_exc, w_exc_nxt;
  logic            w_exc_ld, w_cap_lo, w_cap_hi;
  logic [TAGW-1:0] r_id;
  logic            r_we, r_sxt;
  logic [1:0]      r_sz;
  logic [AMSB:0]   r_adr;
  logic [DBW-1:0]  r_dat, r_rd_lo;
  logic [7:0]      r_tmo;
  logic            w_idle, w_split, w_tmo_hit;
  logic [1:0]      w_la_sz;
  logic [OW-1:0]   w_la_off;
  logic [DBW-1:0]  w_la_dat, w_rd_hi, w_st_lo, w_st_hi, w_ld;
  logic [NB-1:0]   w_sel_lo, w_sel_hi;
  logic [AMSB:0]   w_base;

  // The aligner looks at the incoming request while idle so misalignment is known at accept.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_la_sz   = w_idle ? req_sz_i : r_sz;
  assign w_la_off  = w_idle ? req_adr_i[OW-1:0] : r_adr[OW-1:0];
  assign w_la_dat  = w_idle ? req_dat_i : r_dat;
  assign w_split   = |w_sel_hi;
  assign w_tmo_hit = (r_tmo == 8'(TMO));
  assign w_base    = {r_adr[AMSB:OW], {OW{1'b0}}};

`ifdef MEMISSUE_SPLIT_EN
  localparam logic [AMSB-OW:0] LINE_ONE = 1;
  logic [DBW-1:0] r_rd_hi;
  logic [AMSB:0]  w_base_hi;
  assign w_base_hi = {r_adr[AMSB:OW] + LINE_ONE, {OW{1'b0}}};
  assign w_rd_hi   = r_rd_hi;
`else
  assign w_rd_hi   = '0;
`endif

  lane_align #(.DBW(DBW)) u_align (
    .i_sz     (w_la_sz),
    .i_off    (w_la_off),
    .i_sxt    (r_sxt),
    .i_st_dat (w_la_dat),
    .i_rd_lo  (r_rd_lo),
    .i_rd_hi  (w_rd_hi),
    .o_sel_lo (w_sel_lo),
    .o_sel_hi (w_sel_hi),
    .o_st_lo  (w_st_lo),
    .o_st_hi  (w_st_hi),
    .o_ld_dat (w_ld)
  );

  // Next-state, exception capture and bus drive; bus outputs are quiet outside an access.
  always_comb begin
    w_nxt     = r_state;
    w_exc_ld  = 1'b0;
    w_exc_nxt = EXC_NONE;
    w_cap_lo  = 1'b0;
    w_cap_hi  = 1'b0;
    cyc_o     = 1'b0;
    stb_o     = 1'b0;
    we_o      = 1'b0;
    sel_o     = '0;
    adr_o     = '0;
    dat_o     = '0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_exc_ld = 1'b1;
          w_nxt    = ST_ACC1;
`ifndef MEMISSUE_SPLIT_EN
          if (w_split) begin
            w_nxt     = ST_DONE;
            w_exc_nxt = EXC_ALIGN;
          end
`endif
        end
      end
      ST_ACC1: begin
        if (!w_tmo_hit) begin
          cyc_o = 1'b1;
          stb_o = 1'b1;
          we_o  = r_we;
          sel_o = w_sel_lo;
          adr_o = w_base;
`ifdef MEMISSUE_SPLIT_EN
          dat_o = w_st_lo;
`else
          // Only unsplit accesses reach here, so the high half is always zero.
          dat_o = w_st_lo | w_st_hi;
`endif
        end
        if (w_tmo_hit) begin
          w_nxt = ST_DONE; w_exc_ld = 1'b1; w_exc_nxt = EXC_TMO;
        end else if (err_i) begin
          w_nxt = ST_DONE; w_exc_ld = 1'b1; w_exc_nxt = EXC_BUS;
        end else if (ack_i) begin
          w_cap_lo = 1'b1;
`ifdef MEMISSUE_SPLIT_EN
          w_nxt = w_split ? ST_GAP : ST_DONE;
`else
          w_nxt = ST_DONE;
`endif
        end
      end
`ifdef MEMISSUE_SPLIT_EN
      ST_GAP: begin
        cyc_o = 1'b1;
        we_o  = r_we;
        w_nxt = ST_ACC2;
      end
      ST_ACC2: begin
        if (!w_tmo_hit) begin
          cyc_o = 1'b1;
          stb_o = 1'b1;
          we_o  = r_we;
          sel_o = w_sel_hi;
          adr_o = w_base_hi;
          dat_o = w_st_hi;
        end
        if (w_tmo_hit) begin
          w_nxt = ST_DONE; w_exc_ld = 1'b1; w_exc_nxt = EXC_TMO;
        end else if (err_i) begin
          w_nxt = ST_DONE; w_exc_ld = 1'b1; w_exc_nxt = EXC_BUS;
        end else if (ack_i) begin
          w_cap_hi = 1'b1;
          w_nxt    = ST_DONE;
        end
      end
`endif
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // State, exception and wait counter; the counter restarts on every bus-cycle entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_exc   <= EXC_NONE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_exc_ld) r_exc <= w_exc_nxt;
      if ((r_state == ST_ACC1 || r_state == ST_ACC2) && w_nxt == r_state)
        r_tmo <= r_tmo + 8'd1;
      else
        r_tmo <= '0;
    end
  end

  // Request latch at accept and read-data capture on each acknowledged cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id    <= '0;
      r_we    <= 1'b0;
      r_sz    <= '0;
      r_sxt   <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rd_lo <= '0;
`ifdef MEMISSUE_SPLIT_EN
      r_rd_hi <= '0;
`endif
    end else begin
      if (w_idle && req_valid_i) begin
        r_id  <= req_id_i;
        r_we  <= req_we_i;
        r_sz  <= req_sz_i;
        r_sxt <= req_sxt_i;
        r_adr <= req_adr_i;
        r_dat <= req_dat_i;
      end
      if (w_cap_lo) r_rd_lo <= dat_i;
`ifdef MEMISSUE_SPLIT_EN
      if (w_cap_hi) r_rd_hi <= dat_i;
`endif
    end
  end

  assign req_ready_o = w_idle;
  assign idle_o      = w_idle;
  assign res_valid_o = (r_state == ST_DONE);
  assign res_id_o    = res_valid_o ? r_id : '0;
  assign res_exc_o   = res_valid_o ? r_exc : EXC_NONE;
  assign res_dat_o   = (res_valid_o && !r_we && r_exc == EXC_NONE) ? w_ld : '0;

endmodule
